// File: rtl/pmem_load_ctrl.sv
// Program-memory load sequencer: packs host bytes into instructions, writes them through
// the PMem load port, verifies a trailing checksum and then releases the CPU.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no load active, CPU held in reset, waiting for start
// LO    | waiting for the low byte of the current word
// HI    | waiting for the high byte of the current word
// WR    | one-cycle PMem write of the assembled word
// CHK   | waiting for the checksum byte
// RUN   | load verified, fetch enabled, CPU released
module pmem_load_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 12
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [ADDR_W-1:0]  len_i,
   input  logic               in_valid_i,
   input  logic [7:0]         in_data_i,
   output logic               in_ready_o,
   output logic               pmem_le_o,
   output logic [ADDR_W-1:0]  pmem_la_o,
   output logic [INSTR_W-1:0] pmem_li_o,
   output logic               pmem_e_o,
   output logic               cpu_hold_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      WR   = 3'd3,
      CHK  = 3'd4,
      RUN  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  len_q,   len_d;
   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic [7:0]         sum_q,   sum_d;
   logic [7:0]         lo_q,    lo_d;
   logic [ADDR_W-1:0]  la_q,    la_d;
   logic [INSTR_W-1:0] li_q,    li_d;
   logic               err_q,   err_d;
   logic               done_q,  done_d;

   logic               accept;
   logic               xfer;

   assign accept = (state_q == LO) || (state_q == HI) || (state_q == CHK);
   assign xfer   = accept && in_valid_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         addr_q  <= '0;
         sum_q   <= '0;
         lo_q    <= '0;
         la_q    <= '0;
         li_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         lo_q    <= lo_d;
         la_q    <= la_d;
         li_q    <= li_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      lo_d    = lo_q;
      la_d    = la_q;
      li_d    = li_q;
      err_d   = err_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE, RUN: begin
            if (start_i) begin
               state_d = LO;
               len_d   = len_i;
               addr_d  = '0;
               sum_d   = '0;
               err_d   = 1'b0;
            end
         end
         LO: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (xfer) begin
               lo_d    = in_data_i;
               sum_d   = sum_q + in_data_i;
               state_d = HI;
            end
         end
         HI: begin
            // Load-port address/data are captured here so they are stable during WR
            // and simply hold afterwards.
            if (abort_i) begin
               state_d = IDLE;
            end else if (xfer) begin
               la_d    = addr_q;
               li_d    = {in_data_i[INSTR_W-9:0], lo_q};
               sum_d   = sum_q + in_data_i;
               state_d = WR;
            end
         end
         WR: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (addr_q == len_q) begin
               state_d = CHK;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = LO;
            end
         end
         CHK: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (xfer) begin
               if (in_data_i == sum_q) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready_o = accept;
   assign pmem_le_o  = (state_q == WR);
   assign pmem_la_o  = la_q;
   assign pmem_li_o  = li_q;
   assign pmem_e_o   = (state_q == RUN);
   assign cpu_hold_o = (state_q != RUN);
   assign busy_o     = accept || (state_q == WR);
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule
